// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: machine word and the multiply sequencer state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } lc3b_mul_state;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add multiply datapath: operand shift registers and accumulator, result modulo 2^WIDTH.
module mul_datapath #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      // Bits shifted past WIDTH are dropped, so overflow never reaches acc.
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/ex_mul_sequencer.sv
// EX-stage multi-cycle multiply sequencer: FSM, iteration counter and pipeline stall generation.
module ex_mul_sequencer
  import lc3b_types::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             is_mul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             downstream_ready,
  output logic             stall_out,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  localparam int unsigned CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  lc3b_mul_state state, state_next;
  logic [CW-1:0] cnt;
  logic          load;
  logic          step;
  logic [WIDTH-1:0] acc;

  mul_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    (a),
    .b    (b),
    .acc  (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= MUL_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + CW'(1);
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    stall_out  = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (valid_in && is_mul && !flush) begin
          load       = 1'b1;
          stall_out  = 1'b1;
          state_next = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        stall_out = 1'b1;
        if (flush) begin
          state_next = MUL_IDLE;
        end else begin
          step = 1'b1;
          if (cnt == LAST) state_next = MUL_DONE;
        end
      end
      MUL_DONE: begin
        stall_out = !downstream_ready;
        if (flush || downstream_ready) state_next = MUL_IDLE;
      end
      default: state_next = MUL_IDLE;
    endcase
  end

  assign busy         = (state != MUL_IDLE);
  assign result_valid = (state == MUL_DONE);
  assign result       = result_valid ? acc : '0;

endmodule
